// File: rtl/kf_seq_pkg.sv
// Shared constants for the Kalman-filter bank sequencer: state codes, opcodes,
// router select codes and instruction field positions.
package kf_seq_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FETCH   = 3'd1;
    localparam logic [2:0] ST_DECODE  = 3'd2;
    localparam logic [2:0] ST_ISSUE   = 3'd3;
    localparam logic [2:0] ST_WAIT_AU = 3'd4;
    localparam logic [2:0] ST_WB      = 3'd5;
    localparam logic [2:0] ST_DONE    = 3'd6;

    localparam logic [2:0] OP_END  = 3'd0;
    localparam logic [2:0] OP_AUOP = 3'd1;
    localparam logic [2:0] OP_CLR  = 3'd2;
    localparam logic [2:0] OP_SET  = 3'd3;

    localparam logic [1:0] SD_DIN  = 2'd0;
    localparam logic [1:0] SD_RES  = 2'd1;
    localparam logic [1:0] SD_ZERO = 2'd2;
    localparam logic [1:0] SD_ONES = 2'd3;

    localparam logic [1:0] SW_EXT   = 2'd0;
    localparam logic [1:0] SW_GATED = 2'd1;
    localparam logic [1:0] SW_OFF   = 2'd2;
    localparam logic [1:0] SW_ON    = 2'd3;

    localparam int OPC_LSB  = 18;
    localparam int FUNC_LSB = 15;
    localparam int DEST_LSB = 10;
    localparam int SRCA_LSB = 5;
    localparam int SRCB_LSB = 0;

endpackage

// File: rtl/kf_seq_decode.sv
// Combinational split of a program word into fields plus opcode class flags.
module kf_seq_decode
    import kf_seq_pkg::*;
#(
    parameter int IW    = 21,
    parameter int ADDRW = 5
) (
    input  logic [IW-1:0]    instr,
    output logic [2:0]       func,
    output logic [ADDRW-1:0] dest,
    output logic [ADDRW-1:0] srca,
    output logic [ADDRW-1:0] srcb,
    output logic             op_end,
    output logic             op_au,
    output logic             op_wr,
    output logic             wr_ones
);
    logic [2:0] opc;

    assign opc     = instr[OPC_LSB +: 3];
    assign func    = instr[FUNC_LSB +: 3];
    assign dest    = instr[DEST_LSB +: ADDRW];
    assign srca    = instr[SRCA_LSB +: ADDRW];
    assign srcb    = instr[SRCB_LSB +: ADDRW];
    assign op_end  = (opc == OP_END);
    assign op_au   = (opc == OP_AUOP);
    // Codes 4-7 fall through every flag and execute as NOP.
    assign op_wr   = (opc == OP_CLR) || (opc == OP_SET);
    assign wr_ones = (opc == OP_SET);
endmodule

// File: rtl/kf_bank_sequencer.sv
// Program sequencer for the Data Bank router and AU: fetch/decode/issue/writeback
// with registered (Moore) router controls and READY ownership.
module kf_bank_sequencer
    import kf_seq_pkg::*;
#(
    parameter int ADDRW = 5,
    parameter int PCW   = 6,
    parameter int IW    = 21,
    parameter int TMO   = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [PCW-1:0]   instr_addr,
    input  logic [IW-1:0]    instr_data,
    output logic             au_start,
    output logic [2:0]       au_func,
    input  logic             au_done,
    output logic [ADDRW-1:0] ctl_a,
    output logic [ADDRW-1:0] ctl_b,
    output logic [1:0]       sel_data,
    output logic             sel_dira,
    output logic             sel_dirb,
    output logic [1:0]       sel_write,
    output logic             ready,
    output logic             done,
    output logic             err
);
    localparam int CW = (TMO < 2) ? 1 : $clog2(TMO + 1);

    logic [2:0]       state;
    logic [PCW-1:0]   pc;
    logic [CW-1:0]    cnt;
    logic [ADDRW-1:0] dest_q;

    logic [2:0]       d_func;
    logic [ADDRW-1:0] d_dest, d_srca, d_srcb;
    logic             d_end, d_au, d_wr, d_ones;

    assign instr_addr = pc;

    kf_seq_decode #(.IW(IW), .ADDRW(ADDRW)) u_dec (
        .instr   (instr_data),
        .func    (d_func),
        .dest    (d_dest),
        .srca    (d_srca),
        .srcb    (d_srcb),
        .op_end  (d_end),
        .op_au   (d_au),
        .op_wr   (d_wr),
        .wr_ones (d_ones)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            pc        <= '0;
            cnt       <= '0;
            dest_q    <= '0;
            ready     <= 1'b1;
            sel_dira  <= 1'b1;
            sel_dirb  <= 1'b1;
            sel_data  <= SD_DIN;
            sel_write <= SW_OFF;
            ctl_a     <= '0;
            ctl_b     <= '0;
            au_start  <= 1'b0;
            au_func   <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else if (abort) begin
            // Parks in IDLE with the write path off for one cycle; err survives.
            state     <= ST_IDLE;
            pc        <= '0;
            ready     <= 1'b1;
            sel_dira  <= 1'b1;
            sel_dirb  <= 1'b1;
            sel_data  <= SD_DIN;
            sel_write <= SW_OFF;
            au_start  <= 1'b0;
            done      <= 1'b0;
        end else begin
            au_start <= 1'b0;
            done     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    ready     <= 1'b1;
                    sel_dira  <= 1'b1;
                    sel_dirb  <= 1'b1;
                    sel_data  <= SD_DIN;
                    sel_write <= SW_GATED;
                    if (start) begin
                        pc        <= '0;
                        err       <= 1'b0;
                        ready     <= 1'b0;
                        sel_write <= SW_OFF;
                        state     <= ST_FETCH;
                    end
                end
                ST_FETCH: state <= ST_DECODE;
                ST_DECODE: begin
                    dest_q <= d_dest;
                    if (d_end) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else if (d_au) begin
                        ctl_a    <= d_srca;
                        ctl_b    <= d_srcb;
                        sel_dira <= 1'b0;
                        sel_dirb <= 1'b0;
                        au_func  <= d_func;
                        au_start <= 1'b1;
                        state    <= ST_ISSUE;
                    end else if (d_wr) begin
                        ctl_a     <= d_dest;
                        sel_dira  <= 1'b0;
                        sel_data  <= d_ones ? SD_ONES : SD_ZERO;
                        sel_write <= SW_ON;
                        state     <= ST_WB;
                    end else if (pc == '1) begin
                        // NOP in the last slot also runs off the end of the program.
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        pc    <= pc + PCW'(1);
                        state <= ST_FETCH;
                    end
                end
                ST_ISSUE: begin
                    cnt   <= '0;
                    state <= ST_WAIT_AU;
                end
                ST_WAIT_AU: begin
                    if (au_done) begin
                        ctl_a     <= dest_q;
                        sel_dira  <= 1'b0;
                        sel_data  <= SD_RES;
                        sel_write <= SW_ON;
                        state     <= ST_WB;
                    end else if (cnt == CW'(TMO - 1)) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_WB: begin
                    sel_write <= SW_OFF;
                    pc        <= pc + PCW'(1);
                    if (pc == '1) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        state <= ST_FETCH;
                    end
                end
                ST_DONE: begin
                    ready     <= 1'b1;
                    sel_dira  <= 1'b1;
                    sel_dirb  <= 1'b1;
                    sel_data  <= SD_DIN;
                    sel_write <= SW_GATED;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_kf_bank_sequencer.sv
// Directed bench: main sequencer (PCW=6, TMO=8) plus a PCW=2 instance for program overrun.
module tb_kf_bank_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start = 1'b0, abort = 1'b0, au_done = 1'b0;
    logic [5:0]  instr_addr;
    logic [20:0] instr_data = '0;
    logic        au_start, sel_dira, sel_dirb, ready, done, err;
    logic [2:0]  au_func;
    logic [4:0]  ctl_a, ctl_b;
    logic [1:0]  sel_data, sel_write;

    logic        start2 = 1'b0, abort2 = 1'b0, au_done2 = 1'b0;
    logic [1:0]  instr_addr2;
    logic [20:0] instr_data2 = '0;
    logic        au_start2, sel_dira2, sel_dirb2, ready2, done2, err2;
    logic [2:0]  au_func2;
    logic [4:0]  ctl_a2, ctl_b2;
    logic [1:0]  sel_data2, sel_write2;

    logic [20:0] rom  [64];
    logic [20:0] rom2 [4];

    kf_bank_sequencer #(.ADDRW(5), .PCW(6), .IW(21), .TMO(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .instr_addr(instr_addr), .instr_data(instr_data),
        .au_start(au_start), .au_func(au_func), .au_done(au_done),
        .ctl_a(ctl_a), .ctl_b(ctl_b), .sel_data(sel_data),
        .sel_dira(sel_dira), .sel_dirb(sel_dirb), .sel_write(sel_write),
        .ready(ready), .done(done), .err(err)
    );

    kf_bank_sequencer #(.ADDRW(5), .PCW(2), .IW(21), .TMO(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
        .instr_addr(instr_addr2), .instr_data(instr_data2),
        .au_start(au_start2), .au_func(au_func2), .au_done(au_done2),
        .ctl_a(ctl_a2), .ctl_b(ctl_b2), .sel_data(sel_data2),
        .sel_dira(sel_dira2), .sel_dirb(sel_dirb2), .sel_write(sel_write2),
        .ready(ready2), .done(done2), .err(err2)
    );

    // Synchronous program ROMs
    always @(posedge clk) begin
        instr_data  <= rom[instr_addr];
        instr_data2 <= rom2[instr_addr2];
    end

    int checks = 0, errors = 0;
    int ncyc = 0, since = -1, au_lat = 0;
    int n_aust, aus_cyc, n_wb, n_done, done_cyc, n_sw0, n_wb2, n_done2;
    logic [4:0] aus_a, aus_b, wb_addr [8], wb2_addr [8];
    logic [2:0] aus_f;
    logic [1:0] wb_sd [8], wb2_sd [8];
    int wb_cyc [8];

    function automatic logic [20:0] mk(input logic [2:0] opc, input logic [2:0] fn,
                                       input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
        return {opc, fn, d, a, b};
    endfunction

    task automatic clr_mon();
        n_aust = 0; n_wb = 0; n_done = 0; n_sw0 = 0; n_wb2 = 0; n_done2 = 0;
        aus_cyc = 0; done_cyc = 0; since = -1;
    endtask

    task automatic load_end();
        for (int i = 0; i < 64; i++) rom[i] = mk(3'd0, 3'd0, 5'd0, 5'd0, 5'd0);
    endtask

    // One clock: sample outputs at the falling edge, then step the AU model.
    task automatic cyc();
        @(negedge clk);
        ncyc++;
        if (au_start) begin n_aust++; aus_cyc = ncyc; aus_a = ctl_a; aus_b = ctl_b; aus_f = au_func; end
        if (sel_write == 2'd3) begin
            if (n_wb < 8) begin wb_addr[n_wb] = ctl_a; wb_sd[n_wb] = sel_data; wb_cyc[n_wb] = ncyc; end
            n_wb++;
        end
        if (sel_write == 2'd0) n_sw0++;
        if (done) begin n_done++; done_cyc = ncyc; end
        if (sel_write2 == 2'd3) begin
            if (n_wb2 < 8) begin wb2_addr[n_wb2] = ctl_a2; wb2_sd[n_wb2] = sel_data2; end
            n_wb2++;
        end
        if (done2) n_done2++;
        if (au_start) since = 0;
        else if (since >= 0) since++;
        au_done = (au_lat > 0) && (since == au_lat);
    endtask

    task automatic wait_done(input int d0, input int budget);
        bit ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            cyc();
            if (n_done != d0) ok = 1;
        end
        cyc(); cyc();
        checks++; if (!ok) begin errors++; $display("FAIL done_wait got none want pulse within %0d", budget); end
    endtask

    task automatic run(input int budget);
        int d0;
        d0 = n_done;
        start = 1'b1; cyc(); start = 1'b0;
        wait_done(d0, budget);
    endtask

    task automatic test_reset();
        cyc();
        checks++; if ({ready, sel_dira, sel_dirb, sel_data, sel_write, ctl_a, ctl_b, au_start, au_func, done, err, instr_addr} !==
                      {1'b1, 1'b1, 1'b1, 2'd0, 2'd2, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 6'd0}) begin
            errors++; $display("FAIL reset_vals got rdy=%0d dira=%0d sw=%0d a=%0d want rdy=1 dira=1 sw=2 a=0", ready, sel_dira, sel_write, ctl_a);
        end
        checks++; if ({ready2, sel_dira2, sel_dirb2, sel_write2, ctl_b2, au_func2, au_start2, instr_addr2} !==
                      {1'b1, 1'b1, 1'b1, 2'd2, 5'd0, 3'd0, 1'b0, 2'd0}) begin
            errors++; $display("FAIL reset_vals2 got rdy=%0d sw=%0d want rdy=1 sw=2", ready2, sel_write2);
        end
        rst_n = 1'b1;
        cyc();
        checks++; if (sel_write !== 2'd1) begin errors++; $display("FAIL idle_sel_write got %0d want 1", sel_write); end
        checks++; if ({ready, sel_dira, sel_dirb} !== 3'b111) begin errors++; $display("FAIL idle_host got %b want 111", {ready, sel_dira, sel_dirb}); end
        begin
            int bad = 0;
            for (int i = 0; i < 20; i++) begin
                cyc();
                if ({ready, sel_write, sel_dira, sel_dirb, done, au_start, err} !== {1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) bad++;
            end
            checks++; if (bad != 0) begin errors++; $display("FAIL idle_stable got %0d bad cycles want 0", bad); end
        end
    endtask

    task automatic test_auop();
        load_end();
        rom[0] = mk(3'd1, 3'd2, 5'd7, 5'd3, 5'd4);
        au_lat = 5; clr_mon();
        run(40);
        checks++; if (n_aust !== 1) begin errors++; $display("FAIL au_start_count got %0d want 1", n_aust); end
        checks++; if ({aus_a, aus_b, aus_f} !== {5'd3, 5'd4, 3'd2}) begin
            errors++; $display("FAIL issue_fields got a=%0d b=%0d f=%0d want a=3 b=4 f=2", aus_a, aus_b, aus_f);
        end
        checks++; if (n_wb !== 1) begin errors++; $display("FAIL auop_wb_count got %0d want 1", n_wb); end
        checks++; if ({wb_addr[0], wb_sd[0]} !== {5'd7, 2'd1}) begin
            errors++; $display("FAIL auop_wb got addr=%0d sd=%0d want addr=7 sd=1", wb_addr[0], wb_sd[0]);
        end
        checks++; if (wb_cyc[0] - aus_cyc !== 6) begin errors++; $display("FAIL auop_latency got %0d want 6", wb_cyc[0] - aus_cyc); end
        checks++; if ({n_done == 1, ready, err} !== 3'b110) begin
            errors++; $display("FAIL auop_end got done=%0d rdy=%0d err=%0d want done=1 rdy=1 err=0", n_done, ready, err);
        end
    endtask

    task automatic test_clr_set();
        load_end();
        rom[0] = mk(3'd2, 3'd0, 5'd1, 5'd0, 5'd0);
        rom[1] = mk(3'd3, 3'd0, 5'd2, 5'd0, 5'd0);
        rom[2] = mk(3'd5, 3'd0, 5'd0, 5'd0, 5'd0);
        au_lat = 5; clr_mon();
        start = 1'b1; cyc(); start = 1'b0;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL busy_ready got %0d want 0", ready); end
        wait_done(0, 40);
        checks++; if (n_wb !== 2) begin errors++; $display("FAIL clrset_wb_count got %0d want 2", n_wb); end
        checks++; if ({wb_addr[0], wb_sd[0], wb_addr[1], wb_sd[1]} !== {5'd1, 2'd2, 5'd2, 2'd3}) begin
            errors++; $display("FAIL clrset_wb got %0d/%0d %0d/%0d want 1/2 2/3", wb_addr[0], wb_sd[0], wb_addr[1], wb_sd[1]);
        end
        checks++; if (wb_cyc[1] - wb_cyc[0] !== 3) begin errors++; $display("FAIL clrset_spacing got %0d want 3", wb_cyc[1] - wb_cyc[0]); end
        checks++; if ({n_aust == 0, n_done == 1, err} !== 3'b110) begin
            errors++; $display("FAIL clrset_end got aus=%0d done=%0d err=%0d want 0 1 0", n_aust, n_done, err);
        end
    endtask

    task automatic test_timeout();
        load_end();
        rom[0] = mk(3'd1, 3'd1, 5'd9, 5'd5, 5'd6);
        au_lat = 0; clr_mon();
        run(40);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_err got %0d want 1", err); end
        checks++; if (done_cyc - aus_cyc !== 9) begin errors++; $display("FAIL tmo_wait got %0d want 9", done_cyc - aus_cyc); end
        checks++; if ({n_wb == 0, n_done == 1} !== 2'b11) begin
            errors++; $display("FAIL tmo_nowrite got wb=%0d done=%0d want 0 1", n_wb, n_done);
        end
        au_lat = 5; clr_mon();
        start = 1'b1; cyc(); start = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear got %0d want 0", err); end
        wait_done(0, 40);
        checks++; if ({err, n_wb == 1} !== 2'b01) begin errors++; $display("FAIL rerun got err=%0d wb=%0d want 0 1", err, n_wb); end
    endtask

    task automatic test_abort();
        load_end();
        rom[0] = mk(3'd1, 3'd2, 5'd7, 5'd3, 5'd4);
        au_lat = 0; clr_mon();
        start = 1'b1; cyc(); start = 1'b0;
        for (int i = 0; i < 10 && n_aust == 0; i++) cyc();
        cyc(); cyc();
        abort = 1'b1; cyc(); abort = 1'b0;
        checks++; if ({sel_write, au_start, ready} !== {2'd2, 1'b0, 1'b1}) begin
            errors++; $display("FAIL abort_idle got sw=%0d aus=%0d rdy=%0d want 2 0 1", sel_write, au_start, ready);
        end
        cyc();
        checks++; if (sel_write !== 2'd1) begin errors++; $display("FAIL abort_then got %0d want 1", sel_write); end
        cyc(); cyc(); cyc();
        checks++; if ({n_done, n_wb} !== {32'd0, 32'd0}) begin errors++; $display("FAIL abort_quiet got done=%0d wb=%0d want 0 0", n_done, n_wb); end
        au_lat = 5; clr_mon();
        run(40);
        checks++; if ({n_aust == 1, aus_a, n_wb == 1, wb_addr[0], n_done == 1} !== {1'b1, 5'd3, 1'b1, 5'd7, 1'b1}) begin
            errors++; $display("FAIL abort_rerun got aus=%0d a=%0d wb=%0d d=%0d want 1 3 1 7", n_aust, aus_a, n_wb, wb_addr[0]);
        end
    endtask

    task automatic test_async_reset();
        load_end();
        rom[0] = mk(3'd1, 3'd2, 5'd7, 5'd3, 5'd4);
        au_lat = 0; clr_mon();
        start = 1'b1; cyc(); start = 1'b0;
        for (int i = 0; i < 10 && n_aust == 0; i++) cyc();
        cyc();
        rst_n = 1'b0; #1;
        checks++; if ({ctl_a, sel_write, sel_dira, ready} !== {5'd0, 2'd2, 1'b1, 1'b1}) begin
            errors++; $display("FAIL async_reset got a=%0d sw=%0d dira=%0d rdy=%0d want 0 2 1 1", ctl_a, sel_write, sel_dira, ready);
        end
        #1 rst_n = 1'b1;
        cyc(); cyc();
    endtask

    task automatic test_overrun();
        bit ok = 0;
        rom2[0] = mk(3'd2, 3'd0, 5'd1, 5'd0, 5'd0);
        rom2[1] = mk(3'd2, 3'd0, 5'd2, 5'd0, 5'd0);
        rom2[2] = mk(3'd4, 3'd0, 5'd0, 5'd0, 5'd0);
        rom2[3] = mk(3'd3, 3'd0, 5'd3, 5'd0, 5'd0);
        clr_mon();
        start2 = 1'b1; cyc(); start2 = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            start2 = (i == 4);
            cyc();
            if (n_done2 != 0) ok = 1;
        end
        start2 = 1'b0;
        cyc(); cyc();
        checks++; if (!ok) begin errors++; $display("FAIL overrun_done got none want pulse"); end
        checks++; if (n_wb2 !== 3) begin errors++; $display("FAIL overrun_wb_count got %0d want 3", n_wb2); end
        checks++; if ({wb2_addr[2], wb2_sd[2]} !== {5'd3, 2'd3}) begin
            errors++; $display("FAIL overrun_last got %0d/%0d want 3/3", wb2_addr[2], wb2_sd[2]);
        end
        checks++; if ({err2, n_done2 == 1, ready2} !== 3'b111) begin
            errors++; $display("FAIL overrun_end got err=%0d done=%0d rdy=%0d want 1 1 1", err2, n_done2, ready2);
        end
    endtask

    initial begin
        load_end();
        for (int i = 0; i < 4; i++) rom2[i] = '0;
        clr_mon();
        test_reset();
        test_auop();
        test_clr_set();
        test_timeout();
        test_abort();
        test_async_reset();
        test_overrun();
        checks++; if (n_sw0 !== 0) begin errors++; $display("FAIL sel_write_zero got %0d want 0", n_sw0); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/kf_bank_sequencer.md
Name: kf_bank_sequencer

Overview:
- Sequences the Data Bank router and the arithmetic unit (AU) for one Kalman-filter update program.
- Fetches 21-bit instructions from an external synchronous program ROM and drives router address/select controls (ctl_a, ctl_b, sel_data, sel_dira, sel_dirb, sel_write).
- Handshakes with the AU (start/done) and writes AU results back into the Data Bank.
- Owns READY: the external host may access the Data Bank only while the sequencer is idle.

Parameters:
- ADDRW, 5, Data Bank address width.
- PCW, 6, program counter width (program depth 2^PCW).
- IW, 21, instruction width.
- TMO, 255, maximum AU wait cycles before timeout error.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: run program from pc=0 (honoured only in IDLE)
- abort  in  1  synchronous abort, any state
- instr_addr  out  PCW  program ROM address
- instr_data  in  IW  ROM data, valid one cycle after instr_addr
- au_start  out  1  one-cycle AU launch pulse
- au_func  out  3  AU function code
- au_done  in  1  AU result valid in SR (pulse)
- ctl_a  out  ADDRW  router address A
- ctl_b  out  ADDRW  router address B
- sel_data  out  2  0=DATA_IN 1=result 2=zero 3=all-ones
- sel_dira  out  1  1=host DIR
- sel_dirb  out  1  1=host DIR
- sel_write  out  2  0=WRITE 1=WRITE&READY 2=off 3=forced on
- ready  out  1  host may access bank
- done  out  1  one-cycle program-complete pulse
- err  out  1  sticky error; cleared by next accepted start

Behaviour:
- Instruction fields: [20:18] opc, [17:15] func, [14:10] dest, [9:5] srca, [4:0] srcb.
- Opcodes: 0 END, 1 AUOP, 2 CLR, 3 SET, 4-7 NOP.
- All outputs are registered (Moore). Reset values: state IDLE, pc=0, ready=1, sel_dira=1, sel_dirb=1, sel_data=0, sel_write=2, ctl_a=0, ctl_b=0, au_start=0, au_func=0, done=0, err=0, instr_addr=0.
- IDLE: ready=1, sel_dira=sel_dirb=1, sel_data=0, sel_write=1 (host path). On start: pc<=0, err<=0, ready<=0, sel_write<=2; go to FETCH.
- FETCH (1 cycle): instr_addr=pc; go to DECODE.
- DECODE (1 cycle): latch instr_data, then branch on opcode:
  - END: go to DONE.
  - NOP: pc++, go to FETCH.
  - CLR/SET: go to WB with sel_data 2 or 3.
  - AUOP: go to ISSUE.
- ISSUE (1 cycle): ctl_a=srca, ctl_b=srcb, sel_dira=sel_dirb=0, au_func=func, au_start=1. Go to WAIT_AU. au_done during ISSUE is ignored.
- WAIT_AU: hold ctl_a, ctl_b and au_func; count cycles.
  - On au_done: go to WB with sel_data=1.
  - When count reaches TMO with no au_done: err<=1, go to DONE without writing.
- WB (exactly 1 cycle): ctl_a=dest, sel_dira=0, sel_write=3. Then sel_write returns to 2, pc++.
  - If pc was 2^PCW-1 (program ran off the end with no END): err<=1, go to DONE.
  - Otherwise go to FETCH.
- DONE (1 cycle): done=1; go to IDLE. ready rises on IDLE entry.
- AUOP latency: 4 cycles + AU latency from FETCH to end of WB. CLR/SET: 3 cycles.
- start outside IDLE is ignored.
- abort has priority over everything. Next cycle: state IDLE, sel_write=2 for that one cycle (no bank write), au_start=0, pc=0, err unchanged, done not pulsed.
- sel_write is never 3 outside WB. sel_write is never 0.
- Reset asserted mid-program: all outputs return to reset values immediately (asynchronous); no partial write is issued.

Decomposition:
- Package kf_seq_pkg holds:
  - state enum: IDLE, FETCH, DECODE, ISSUE, WAIT_AU, WB, DONE;
  - opcode constants;
  - sel_data codes SD_DIN, SD_RES, SD_ZERO, SD_ONES;
  - sel_write codes SW_EXT, SW_GATED, SW_OFF, SW_ON;
  - instruction field bit positions.
- One natural sub-module: kf_seq_decode (combinational instruction field split and opcode classification).

Test Plan:
- Reset then idle: ready=1, sel_dira=sel_dirb=1, sel_write=1 after first clock; start low -> outputs stable for 20 cycles.
- Program [AUOP func=2 dest=7 srca=3 srcb=4; END], AU model done 5 cycles after start -> exactly one au_start with ctl_a=3, ctl_b=4, au_func=2; one WB cycle with ctl_a=7, sel_data=1, sel_write=3; done pulses once; ready returns to 1; err=0.
- Program [CLR dest=1; SET dest=2; NOP; END] -> WB cycles write address 1 with sel_data=2 and address 2 with sel_data=3, each 3 cycles apart; au_start never asserted.
- AU never returns au_done, TMO=8 -> err=1 after 8 WAIT_AU cycles; no sel_write=3; done pulses; next start clears err.
- abort asserted during WAIT_AU -> next cycle IDLE, sel_write=2 for one cycle then 1, no done pulse; subsequent start executes the program from pc=0.
- PCW=2 program with no END (4 NOPs/CLRs) -> after pc=3 completes, err=1 and done pulses; start asserted mid-run is ignored.
